mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
//  Arbitrates and sequences the single byte-wide external memory/IO bus between two requesters:
//  instruction fetch (IF, 4-byte reads) and load/store buffer (LS, 1/2/4-byte reads or writes).
//  Splits each access into byte transfers, assembles read data little-endian, and holds IO
//  writes while the UART buffer is full. Sits between the core and the mem_* pins of the CPU top.
// PARAMETERS
//  ADDR_W       32  width of request addresses and mem_a
//  IO_STALL_EN  1   1: stall writes to addresses with addr[17:16]==2'b11 while io_buffer_full
// PORTS
//  clk_in          in   1       clock; all state changes on rising edge
//  rst_n_in        in   1       reset, asynchronous, active-low
//  rdy_in          in   1       0 = pause: state frozen, mem_wr forced 0
//  clear_in        in   1       pipeline flush (mispredict): abort reads
//  if_req_in       in   1       IF request, level, held until if_done_out
//  if_addr_in      in   ADDR_W  IF byte address, stable while if_req_in
//  if_done_out     out  1       1-cycle pulse, if_data_out valid
//  if_data_out     out  32      fetched word
//  ls_req_in       in   1       LS request, level, held until ls_done_out
//  ls_we_in        in   1       1 = write
//  ls_size_in      in   2       00 byte, 01 half, 10 word (11 illegal, treated as word)
//  ls_addr_in      in   ADDR_W  LS byte address
//  ls_wdata_in     in   32      write data, byte k = [8k+7:8k]
//  ls_done_out     out  1       1-cycle pulse; read data valid / write finished
//  ls_rdata_out    out  32      read data, zero-extended (sign-extension done by LS)
//  mem_din         in   8       read byte, valid the cycle after its address
//  mem_dout        out  8       write byte
//  mem_a           out  ADDR_W  bus address
//  mem_wr          out  1       1 = write this cycle
//  io_buffer_full  in   1       UART buffer full
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, last_grant=LS (so IF wins first tie). All outputs registered.
//  - FSM: IDLE -> READ | WRITE -> DONE -> IDLE. Requests sampled only in IDLE, and only when rdy_in=1.
//  - Arbitration in IDLE: single requester granted; both -> grant the one != last_grant, then update.
//  - N = 4 for IF, else from ls_size_in. Address of byte k = addr + k, wraps mod 2^ADDR_W.
//  - READ: req sampled at end of cycle 0; byte k address on mem_a in cycle k+1; mem_din captured at
//    end of cycle k+2 into byte lane k; done pulses in cycle N+2 (word: cycle 6). Unused lanes 0.
//  - WRITE: mem_wr=1, mem_dout=byte k, mem_a=addr+k in cycle k+1; done in cycle N+1 (word: 5).
//  - IO stall: if IO_STALL_EN and (addr+k)[17:16]==2'b11 and io_buffer_full=1 at the issuing edge,
//    drive mem_wr=0 and retry byte k next cycle; no limit on stall length.
//  - Outside active write cycles mem_wr=0; mem_a holds its last value; mem_dout don't-care (keep).
//  - DONE: asserts exactly one done pulse for the granted requester; data outputs hold until next
//    done of that port. Requester drops req on the edge ending the done cycle.
//  - rdy_in=0: no state, counter or output register changes except mem_wr forced 0. On resume
//    in READ, re-issue address of first not-yet-captured byte; no capture in that resume cycle.
//    On resume in WRITE, reissue current byte k.
//  - clear_in=1 at an edge: READ (IF or LS) -> IDLE, no done, partial data discarded; IDLE ignores
//    if_req_in that cycle. WRITE unaffected, completes and pulses ls_done_out (stores are committed).
//    A done already high is not retracted; requester discards it.
//  - No alignment requirement; misaligned halves/words issued bytewise as above.
// TESTING
//  1. IF only, addr 0x100, mem bytes 11 22 33 44 -> mem_a 0x100..0x103 cycles 1-4, if_data=0x44332211, done cycle 6.
//  2. LS write size=01 addr 0x2002 data 0xBEEF -> cycle1 a=0x2002 dout=EF wr=1, cycle2 a=0x2003 dout=BE, done cycle 3.
//  3. IF and LS requests both in same cycle after reset -> IF served first, LS next; repeat -> alternation.
//  4. LS byte write to 0x30000 with io_buffer_full=1 for 5 cycles -> mem_wr stays 0, byte written cycle after it drops.
//  5. IF read, clear_in at cycle 3 -> no if_done_out, FSM IDLE; LS word write with clear_in mid-op -> completes, ls_done_out.
//  6. rdy_in low 3 cycles during word read after byte 1 captured -> resume reissues addr+2; data still correct.
//  7. rst_n_in asserted mid-write -> outputs 0 immediately (async), mem_wr=0, no done after release.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: sequences a byte-wide external memory/IO bus between two requesters.
// Instruction fetch (IF) always reads 4 bytes. The load/store buffer (LS) reads or
// writes 1, 2 or 4 bytes. Read bytes are assembled little-endian; IO writes are held
// while the UART buffer is full.
//
// Ports
//   clk_in, rst_n_in        clock, asynchronous active-low reset
//   rdy_in                  0 freezes the controller (mem_wr is forced low)
//   clear_in                pipeline flush; aborts reads, lets writes finish
//   if_req_in/if_addr_in    IF request (level) and byte address
//   if_done_out/if_data_out IF completion pulse and fetched word
//   ls_req_in/ls_we_in/ls_size_in/ls_addr_in/ls_wdata_in   LS request
//   ls_done_out/ls_rdata_out                               LS completion, zero-extended data
//   mem_din/mem_dout/mem_a/mem_wr                          external bus
//   io_buffer_full          UART buffer full
module mem_ctrl #(
  parameter int unsigned ADDR_W      = 32,
  parameter bit          IO_STALL_EN = 1'b1
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              clear_in,
  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  output logic              if_done_out,
  output logic [31:0]       if_data_out,
  input  logic              ls_req_in,
  input  logic              ls_we_in,
  input  logic [1:0]        ls_size_in,
  input  logic [ADDR_W-1:0] ls_addr_in,
  input  logic [31:0]       ls_wdata_in,
  output logic              ls_done_out,
  output logic [31:0]       ls_rdata_out,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_DONE} state_t;

  state_t            state_q, state_n;
  logic              last_ls_q, last_ls_n;     // last grant went to LS
  logic              cur_ls_q, cur_ls_n;       // current access belongs to LS
  logic [ADDR_W-1:0] base_q, base_n;
  logic [1:0]        last_idx_q, last_idx_n;   // index of final byte (N-1)
  logic [1:0]        idx_q, idx_n;             // byte currently on mem_a
  logic [1:0]        cap_q, cap_n;             // next byte lane to capture
  logic              addr_valid_q, addr_valid_n; // mem_a carries a live read address
  logic              rd_valid_q, rd_valid_n;   // mem_din carries byte cap_q this cycle
  logic              paused_q, paused_n;       // a read was frozen by rdy_in=0
  logic [31:0]       wdata_q, wdata_n;
  logic [31:0]       rd_buf_q, rd_buf_n;
  logic              if_done_q, if_done_n;
  logic [31:0]       if_data_q, if_data_n;
  logic              ls_done_q, ls_done_n;
  logic [31:0]       ls_rdata_q, ls_rdata_n;
  logic [ADDR_W-1:0] mem_a_q, mem_a_n;
  logic [7:0]        mem_dout_q, mem_dout_n;
  logic              mem_wr_q, mem_wr_n;

  logic              if_ok;
  logic              pick_ls;
  logic              wr_issue;
  logic [1:0]        k_next;
  logic [ADDR_W-1:0] a_next;

  // Index of the last byte for an LS size code; 11 behaves as a word.
  function automatic logic [1:0] last_of(input logic [1:0] size);
    case (size)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  // Write to the UART window while its buffer is full must be held back.
  function automatic logic io_hit(input logic [ADDR_W-1:0] a, input logic full);
    logic [1:0] win;
    win = 2'(a >> 16);
    return IO_STALL_EN && (win == 2'b11) && full;
  endfunction

  // Next-state and datapath
  always_comb begin
    state_n      = state_q;
    last_ls_n    = last_ls_q;
    cur_ls_n     = cur_ls_q;
    base_n       = base_q;
    last_idx_n   = last_idx_q;
    idx_n        = idx_q;
    cap_n        = cap_q;
    addr_valid_n = addr_valid_q;
    rd_valid_n   = rd_valid_q;
    paused_n     = paused_q;
    wdata_n      = wdata_q;
    rd_buf_n     = rd_buf_q;
    if_done_n    = if_done_q;
    if_data_n    = if_data_q;
    ls_done_n    = ls_done_q;
    ls_rdata_n   = ls_rdata_q;
    mem_a_n      = mem_a_q;
    mem_dout_n   = mem_dout_q;
    mem_wr_n     = 1'b0;
    if_ok        = 1'b0;
    pick_ls      = 1'b0;
    wr_issue     = 1'b0;
    k_next       = idx_q;
    a_next       = base_q;

    if (!rdy_in) begin
      // Frozen: remember that a read lost its in-flight byte.
      if (state_q == ST_READ) paused_n = 1'b1;
    end else begin
      if_done_n = 1'b0;
      ls_done_n = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if_ok = if_req_in && !clear_in;
          if (if_ok || ls_req_in) begin
            // On a tie the requester that was not served last wins.
            pick_ls    = ls_req_in && (!if_ok || !last_ls_q);
            last_ls_n  = pick_ls;
            cur_ls_n   = pick_ls;
            base_n     = pick_ls ? ls_addr_in : if_addr_in;
            last_idx_n = pick_ls ? last_of(ls_size_in) : 2'd3;
            wdata_n    = ls_wdata_in;
            idx_n      = 2'd0;
            cap_n      = 2'd0;
            rd_buf_n   = 32'd0;
            rd_valid_n = 1'b0;
            paused_n   = 1'b0;
            if (pick_ls && ls_we_in) begin
              state_n  = ST_WRITE;
              k_next   = 2'd0;
              wr_issue = 1'b1;
            end else begin
              state_n      = ST_READ;
              mem_a_n      = base_n;
              addr_valid_n = 1'b1;
            end
          end
        end

        ST_READ: begin
          if (clear_in) begin
            state_n      = ST_IDLE;
            addr_valid_n = 1'b0;
            rd_valid_n   = 1'b0;
            paused_n     = 1'b0;
          end else if (paused_q) begin
            // Resume: bus data this cycle is stale, restart at first missing byte.
            paused_n     = 1'b0;
            idx_n        = cap_q;
            mem_a_n      = base_q + ADDR_W'(cap_q);
            addr_valid_n = 1'b1;
            rd_valid_n   = 1'b0;
          end else begin
            rd_valid_n = addr_valid_q;
            if (addr_valid_q) begin
              if (idx_q == last_idx_q) begin
                addr_valid_n = 1'b0;
              end else begin
                idx_n   = idx_q + 2'd1;
                mem_a_n = base_q + ADDR_W'(idx_n);
              end
            end
            if (rd_valid_q) begin
              rd_buf_n[{cap_q, 3'b000} +: 8] = mem_din;
              cap_n = cap_q + 2'd1;
              if (cap_q == last_idx_q) begin
                state_n      = ST_DONE;
                rd_valid_n   = 1'b0;
                addr_valid_n = 1'b0;
                if (cur_ls_q) begin
                  ls_done_n  = 1'b1;
                  ls_rdata_n = rd_buf_n;
                end else begin
                  if_done_n = 1'b1;
                  if_data_n = rd_buf_n;
                end
              end
            end
          end
        end

        ST_WRITE: begin
          // Stores are committed: clear_in is ignored here.
          wr_issue = 1'b1;
          k_next   = idx_q;
          if (mem_wr_q) begin
            if (idx_q == last_idx_q) begin
              wr_issue  = 1'b0;
              state_n   = ST_DONE;
              ls_done_n = 1'b1;
            end else begin
              k_next = idx_q + 2'd1;
            end
          end
        end

        ST_DONE: begin
          state_n = ST_IDLE;
        end

        default: state_n = ST_IDLE;
      endcase

      // Drive byte k_next of a write, or hold it back for the UART.
      if (wr_issue) begin
        a_next     = base_n + ADDR_W'(k_next);
        idx_n      = k_next;
        mem_a_n    = a_next;
        mem_dout_n = wdata_n[{k_next, 3'b000} +: 8];
        mem_wr_n   = !io_hit(a_next, io_buffer_full);
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= ST_IDLE;
      last_ls_q    <= 1'b1;
      cur_ls_q     <= 1'b0;
      base_q       <= '0;
      last_idx_q   <= 2'd0;
      idx_q        <= 2'd0;
      cap_q        <= 2'd0;
      addr_valid_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      paused_q     <= 1'b0;
      wdata_q      <= 32'd0;
      rd_buf_q     <= 32'd0;
      if_done_q    <= 1'b0;
      if_data_q    <= 32'd0;
      ls_done_q    <= 1'b0;
      ls_rdata_q   <= 32'd0;
      mem_a_q      <= '0;
      mem_dout_q   <= 8'd0;
      mem_wr_q     <= 1'b0;
    end else begin
      state_q      <= state_n;
      last_ls_q    <= last_ls_n;
      cur_ls_q     <= cur_ls_n;
      base_q       <= base_n;
      last_idx_q   <= last_idx_n;
      idx_q        <= idx_n;
      cap_q        <= cap_n;
      addr_valid_q <= addr_valid_n;
      rd_valid_q   <= rd_valid_n;
      paused_q     <= paused_n;
      wdata_q      <= wdata_n;
      rd_buf_q     <= rd_buf_n;
      if_done_q    <= if_done_n;
      if_data_q    <= if_data_n;
      ls_done_q    <= ls_done_n;
      ls_rdata_q   <= ls_rdata_n;
      mem_a_q      <= mem_a_n;
      mem_dout_q   <= mem_dout_n;
      mem_wr_q     <= mem_wr_n;
    end
  end

  assign if_done_out  = if_done_q;
  assign if_data_out  = if_data_q;
  assign ls_done_out  = ls_done_q;
  assign ls_rdata_out = ls_rdata_q;
  assign mem_a        = mem_a_q;
  assign mem_dout     = mem_dout_q;
  assign mem_wr       = mem_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed bench for mem_ctrl with a byte-wide memory model on the bus.
module tb_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic        clear;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_req;
  logic        ls_we;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_full;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [logic [31:0]];

  mem_ctrl #(.ADDR_W(32), .IO_STALL_EN(1'b1)) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .rdy_in         (rdy),
    .clear_in       (clear),
    .if_req_in      (if_req),
    .if_addr_in     (if_addr),
    .if_done_out    (if_done),
    .if_data_out    (if_data),
    .ls_req_in      (ls_req),
    .ls_we_in       (ls_we),
    .ls_size_in     (ls_size),
    .ls_addr_in     (ls_addr),
    .ls_wdata_in    (ls_wdata),
    .ls_done_out    (ls_done),
    .ls_rdata_out   (ls_rdata),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'(a);
  endfunction

  // Memory: write on mem_wr, read data valid the cycle after its address.
  always @(posedge clk) begin
    if (mem_wr) mem[mem_a] = mem_dout;
    mem_din <= rd(mem_a);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance until a done pulse or the budget runs out; n = cycles advanced.
  task automatic wait_done(input string tag, input int budget,
                           output logic got_if, output logic got_ls, output int n);
    n = 0;
    while (!(if_done || ls_done) && n < budget) begin
      cyc();
      n++;
    end
    got_if = if_done;
    got_ls = ls_done;
    chk({tag, "_seen"}, 32'(got_if | got_ls), 32'd1);
  endtask

  logic gi, gl, seen;
  int   n;

  initial begin
    rst_n = 1'b1; rdy = 1'b1; clear = 1'b0; io_full = 1'b0;
    if_req = 1'b0; if_addr = 32'd0;
    ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'b00; ls_addr = 32'd0; ls_wdata = 32'd0;
    mem[32'h100] = 8'h11; mem[32'h101] = 8'h22; mem[32'h102] = 8'h33; mem[32'h103] = 8'h44;
    mem[32'h200] = 8'hA1; mem[32'h201] = 8'hB2; mem[32'h202] = 8'hC3; mem[32'h203] = 8'hD4;

    // Reset values
    #1 rst_n = 1'b0;
    #2;
    chk("rst_if_done", 32'(if_done), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
    cyc();

    // IF word fetch
    if_req = 1'b1; if_addr = 32'h100;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      chk($sformatf("t1_a%0d", c), mem_a, 32'h100 + 32'(c - 1));
    end
    cyc(); chk("t1_early", 32'(if_done), 32'd0);
    cyc(); chk("t1_done", 32'(if_done), 32'd1);
    chk("t1_data", if_data, 32'h44332211);
    if_req = 1'b0;
    cyc(); chk("t1_pulse", 32'(if_done), 32'd0);

    // LS half write
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b01; ls_addr = 32'h2002; ls_wdata = 32'h0000BEEF;
    cyc(); chk("t2_a1", mem_a, 32'h2002); chk("t2_d1", 32'(mem_dout), 32'hEF); chk("t2_w1", 32'(mem_wr), 32'd1);
    cyc(); chk("t2_a2", mem_a, 32'h2003); chk("t2_d2", 32'(mem_dout), 32'hBE); chk("t2_w2", 32'(mem_wr), 32'd1);
    cyc(); chk("t2_done", 32'(ls_done), 32'd1); chk("t2_w3", 32'(mem_wr), 32'd0);
    ls_req = 1'b0; ls_we = 1'b0;
    cyc();
    chk("t2_mem", {16'd0, rd(32'h2003), rd(32'h2002)}, 32'h0000BEEF);

    // Simultaneous requests alternate
    if_req = 1'b1; if_addr = 32'h100;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_addr = 32'h200;
    for (int r = 0; r < 4; r++) begin
      wait_done($sformatf("t3_r%0d", r), 20, gi, gl, n);
      chk($sformatf("t3_if%0d", r), 32'(gi), 32'((r % 2) == 0));
      chk($sformatf("t3_ls%0d", r), 32'(gl), 32'((r % 2) == 1));
      chk($sformatf("t3_lat%0d", r), 32'(n), 32'd6);
      if (gl) chk($sformatf("t3_lsd%0d", r), ls_rdata, 32'hD4C3B2A1);
      else    chk($sformatf("t3_ifd%0d", r), if_data, 32'h44332211);
      cyc();
    end
    if_req = 1'b0; ls_req = 1'b0;
    cyc();

    // Misaligned byte and half reads, zero-extended
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b00; ls_addr = 32'h203;
    wait_done("tb_byte", 20, gi, gl, n);
    chk("tb_byte_lat", 32'(n), 32'd3); chk("tb_byte_d", ls_rdata, 32'h000000D4);
    ls_req = 1'b0; cyc();
    ls_req = 1'b1; ls_size = 2'b01; ls_addr = 32'h201;
    wait_done("tb_half", 20, gi, gl, n);
    chk("tb_half_lat", 32'(n), 32'd4); chk("tb_half_d", ls_rdata, 32'h0000C3B2);
    ls_req = 1'b0; cyc();

    // Address wrap on a half write
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b01; ls_addr = 32'hFFFF_FFFF; ls_wdata = 32'h00007766;
    cyc(); chk("tw_a1", mem_a, 32'hFFFF_FFFF); chk("tw_d1", 32'(mem_dout), 32'h66);
    cyc(); chk("tw_a2", mem_a, 32'h0000_0000); chk("tw_d2", 32'(mem_dout), 32'h77);
    cyc(); chk("tw_done", 32'(ls_done), 32'd1);
    ls_req = 1'b0; ls_we = 1'b0; cyc();

    // IO write held while UART buffer full
    io_full = 1'b1;
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b00; ls_addr = 32'h30000; ls_wdata = 32'h0000005A;
    seen = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      cyc();
      seen = seen | mem_wr | ls_done;
      if (c == 5) io_full = 1'b0;
    end
    chk("t4_stalled", 32'(seen), 32'd0);
    cyc(); chk("t4_wr", 32'(mem_wr), 32'd1); chk("t4_a", mem_a, 32'h30000); chk("t4_d", 32'(mem_dout), 32'h5A);
    cyc(); chk("t4_done", 32'(ls_done), 32'd1);
    ls_req = 1'b0; ls_we = 1'b0; cyc();
    // Non-IO window is not held
    io_full = 1'b1;
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b00; ls_addr = 32'h20000; ls_wdata = 32'h0000003C;
    cyc(); chk("t4_nio_wr", 32'(mem_wr), 32'd1);
    cyc(); chk("t4_nio_done", 32'(ls_done), 32'd1);
    ls_req = 1'b0; ls_we = 1'b0; io_full = 1'b0; cyc();

    // Flush aborts an IF read
    if_req = 1'b1; if_addr = 32'h100;
    cyc(); cyc(); cyc();
    clear = 1'b1;
    cyc();
    clear = 1'b0; if_req = 1'b0;
    seen = if_done;
    for (int c = 0; c < 8; c++) begin
      cyc();
      seen = seen | if_done;
    end
    chk("t5_nodone", 32'(seen), 32'd0);
    chk("t5_a_hold", mem_a, 32'h102);
    // Flush in IDLE ignores the IF request for that cycle
    if_req = 1'b1; if_addr = 32'h200; clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("t5_ign", mem_a, 32'h102);
    wait_done("t5_if", 20, gi, gl, n);
    chk("t5_if_lat", 32'(n), 32'd6); chk("t5_if_d", if_data, 32'hD4C3B2A1);
    if_req = 1'b0; cyc();
    // Flush does not abort a write
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b10; ls_addr = 32'h3000; ls_wdata = 32'hCAFEF00D;
    cyc(); cyc();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    wait_done("t5_wr", 10, gi, gl, n);
    chk("t5_wr_ls", 32'(gl), 32'd1); chk("t5_wr_lat", 32'(n), 32'd2);
    chk("t5_wr_mem", {rd(32'h3003), rd(32'h3002), rd(32'h3001), rd(32'h3000)}, 32'hCAFEF00D);
    ls_req = 1'b0; ls_we = 1'b0; cyc();

    // rdy_in pause during a word read
    if_req = 1'b1; if_addr = 32'h200;
    cyc(); cyc(); cyc();
    cyc(); rdy = 1'b0;
    cyc(); chk("t6_frozen_a", mem_a, 32'h203);
    cyc();
    seen = if_done | mem_wr;
    cyc(); rdy = 1'b1;
    cyc(); chk("t6_reissue", mem_a, 32'h202);
    cyc(); chk("t6_next", mem_a, 32'h203);
    cyc(); seen = seen | if_done;
    chk("t6_early", 32'(seen), 32'd0);
    cyc(); chk("t6_done", 32'(if_done), 32'd1); chk("t6_data", if_data, 32'hD4C3B2A1);
    if_req = 1'b0; cyc();

    // Asynchronous reset mid-write
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b10; ls_addr = 32'h4000; ls_wdata = 32'h11223344;
    cyc(); cyc();
    chk("t7_pre_wr", 32'(mem_wr), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("t7_wr", 32'(mem_wr), 32'd0);
    chk("t7_a", mem_a, 32'd0);
    chk("t7_dout", 32'(mem_dout), 32'd0);
    chk("t7_ifd", if_data, 32'd0);
    chk("t7_lsd", ls_rdata, 32'd0);
    ls_req = 1'b0; ls_we = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cyc();
      seen = seen | ls_done | if_done | mem_wr;
    end
    chk("t7_quiet", 32'(seen), 32'd0);

    // After reset IF wins the first tie
    if_req = 1'b1; if_addr = 32'h100;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_addr = 32'h200;
    wait_done("t7_tie", 20, gi, gl, n);
    chk("t7_tie_if", 32'(gi), 32'd1);
    chk("t7_tie_ls", 32'(gl), 32'd0);
    if_req = 1'b0; ls_req = 1'b0;
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
